// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched_pkg: shared FSM state type, default read latency and grant-index width helper
package fifo_rd_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_e;
  localparam int RD_LAT_DEF = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter, combinational winner plus registered last-winner pointer
//   rclk/rst_n : clock, async active-low reset (pointer resets to NREQ-1 so index 0 wins first)
//   req        : request vector
//   upd        : load pointer with the current winner
//   win, any   : winning index and "some request present"
module rr_arb
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ = 4
)(
  input  logic                    rclk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    upd,
  output logic [idx_w(NREQ)-1:0]  win,
  output logic                    any
);
  localparam int IW = idx_w(NREQ);
  logic [IW-1:0] ptr_q, ptr_d;
  // scan downward so the nearest index after the pointer is written last and wins
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--)
      win = req[(int'(ptr_q) + k) % NREQ] ? IW'((int'(ptr_q) + k) % NREQ) : win;
    any = |req;
    ptr_d = upd ? win : ptr_q;
  end
  always_ff @(posedge rclk or negedge rst_n)
    if (!rst_n) ptr_q <= IW'(NREQ - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst read scheduler for a shared FIFO read port
//   rclk/rst_n          : read clock, async active-low reset
//   req/req_len         : per-requester burst request and length-1 field
//   gnt/busy            : one-hot grant pulse, busy outside IDLE
//   rempty/rinc/rdata   : FIFO read port (data RD_LAT cycles after rinc)
//   out_valid/out_data/out_id/out_last : returned words tagged with the owning requester
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 4,
  parameter int LEN_W  = 4,
  parameter int RD_LAT = RD_LAT_DEF
)(
  input  logic                    rclk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  input  logic                    rempty,
  output logic                    rinc,
  input  logic [WIDTH-1:0]        rdata,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [idx_w(NREQ)-1:0]  out_id,
  output logic                    out_last
);
  localparam int IW = idx_w(NREQ);
  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     id_q, id_d, win;
  logic [LEN_W:0]    rem_q, rem_d;
  logic [LEN_W-1:0]  len_sel;
  logic [RD_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
  logic              any, take;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .rclk (rclk),
    .rst_n(rst_n),
    .req  (req),
    .upd  (take),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    take = state_q == IDLE && any;
    len_sel = '0;
    gnt_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      len_sel = (win == IW'(i)) ? req_len[i*LEN_W +: LEN_W] : len_sel;
      gnt_d[i] = take && win == IW'(i);
    end
    rinc = state_q == BURST && !rempty && rem_q != '0;
    state_d = state_q == IDLE  ? (any ? GRANT : IDLE) :
              state_q == GRANT ? BURST :
              state_q == BURST ? ((rinc && rem_q == (LEN_W+1)'(1)) ? DRAIN : BURST) :
              (|pv_q ? DRAIN : IDLE);
    id_d = take ? win : id_q;
    rem_d = take ? {1'b0, len_sel} + (LEN_W+1)'(1) : rem_q - {{LEN_W{1'b0}}, rinc};
    busy_d = state_d != IDLE;
    // one {valid,last} slot per pop, aligned with rdata RD_LAT cycles later
    pv_d = (pv_q << 1) | RD_LAT'(rinc);
    pl_d = (pl_q << 1) | RD_LAT'(rinc && rem_q == (LEN_W+1)'(1));
  end

  always_ff @(posedge rclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      rem_q   <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
    end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign out_valid = pv_q[RD_LAT-1];
  assign out_last  = pl_q[RD_LAT-1];
  assign out_id    = id_q;
  assign out_data  = rdata;
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: randomized and directed bench with a behavioural scheduler model
module tb_fifo_rd_sched;
  localparam int WIDTH = 32, NREQ = 4, LEN_W = 4, RD_LAT = 2;

  logic rclk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, gnt;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic busy, rempty = 1'b1, rinc, out_valid, out_last;
  logic [WIDTH-1:0] rdata = '0, out_data;
  logic [1:0] out_id;

  always #5 rclk = ~rclk;

  fifo_rd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .rclk(rclk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt), .busy(busy),
    .rempty(rempty), .rinc(rinc), .rdata(rdata), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_last(out_last)
  );

  int checks = 0, errors = 0;

  // stimulus controls
  logic [NREQ-1:0] req_hold = '0;
  bit clr_on_gnt = 1, len_rand = 0, empty_force = 0, hold_rst = 1;
  int arr_rate = 0, empty_rate = 0;
  logic [NREQ*LEN_W-1:0] len_fix = '0;
  logic [WIDTH-1:0] nxt_word = 32'h1000;

  // behavioural model: phase 0 idle,1 grant,2 burst,3 drain; returns scheduled by due cycle
  int m_ph, m_id, m_rem, m_ptr, m_last_due, cyc = 0;
  bit m_v[64], m_l[64], env_v[64];
  logic [WIDTH-1:0] m_d[64], env_d[64];
  bit s_pop, e_pop, prev_busy, gp_busy;
  logic [NREQ-1:0] s_gnt;

  int g_log[$], o_id[$], o_cyc[$], pop_cyc[$], pop_cnt;
  logic [WIDTH-1:0] o_data[$];
  bit o_last[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_id = 0; m_rem = 0; m_ptr = NREQ - 1; m_last_due = -100;
    for (int i = 0; i < 64; i++) begin m_v[i] = 0; m_l[i] = 0; env_v[i] = 0; end
  endtask

  task automatic clr_logs();
    g_log.delete(); o_id.delete(); o_cyc.delete(); pop_cyc.delete();
    o_data.delete(); o_last.delete(); pop_cnt = 0;
  endtask

  task automatic compare();
    int s = cyc % 64;
    e_pop = m_ph == 2 && !rempty && m_rem != 0;
    chk("gnt", gnt, m_ph == 1 ? (1 << m_id) : 0);
    chk("busy", busy, m_ph != 0);
    chk("rinc", rinc, e_pop);
    chk("out_valid", out_valid, m_v[s]);
    chk("out_last", out_last, m_l[s]);
    chk("out_id", out_id, m_id);
    if (m_v[s]) chk("out_data", out_data, m_d[s]);
    s_pop = rinc;
    s_gnt = gnt;
    if (|gnt) begin g_log.push_back(oh2i(gnt)); gp_busy = prev_busy; end
    prev_busy = busy;
    if (out_valid) begin
      o_data.push_back(out_data); o_last.push_back(out_last);
      o_id.push_back(out_id); o_cyc.push_back(cyc);
    end
    if (rinc) begin pop_cnt++; pop_cyc.push_back(cyc); end
  endtask

  task automatic advance();
    int s = cyc % 64, d = (cyc + RD_LAT) % 64;
    logic [WIDTH-1:0] w = nxt_word;
    if (!rst_n) model_reset();
    else begin
      if (s_pop) begin env_v[d] = 1; env_d[d] = w; end
      if (s_pop || e_pop) nxt_word++;
      case (m_ph)
        0: if (|req) begin
             for (int k = 1; k <= NREQ; k++)
               if (req[(m_ptr + k) % NREQ]) begin m_id = (m_ptr + k) % NREQ; break; end
             m_rem = req_len[m_id*LEN_W +: LEN_W] + 1;
             m_ptr = m_id;
             m_ph = 1;
           end
        1: m_ph = 2;
        2: if (e_pop) begin
             m_v[d] = 1; m_l[d] = (m_rem == 1); m_d[d] = w;
             m_last_due = cyc + RD_LAT;
             m_rem--;
             if (m_rem == 0) m_ph = 3;
           end
        default: if (m_last_due < cyc) m_ph = 0;
      endcase
      if (clr_on_gnt) for (int i = 0; i < NREQ; i++) if (s_gnt[i]) req_hold[i] = 0;
    end
    m_v[s] = 0; m_l[s] = 0; env_v[s] = 0;
    cyc++;
  endtask

  task automatic step();
    @(negedge rclk);
    rst_n = !hold_rst;
    if (arr_rate > 0)
      for (int i = 0; i < NREQ; i++) if ($urandom_range(arr_rate - 1, 0) == 0) req_hold[i] = 1;
    req = req_hold;
    if (len_rand) for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
    else req_len = len_fix;
    rempty = empty_force || (empty_rate > 0 && $urandom_range(empty_rate - 1, 0) == 0);
    rdata = env_v[cyc % 64] ? env_d[cyc % 64] : $urandom;
    #1;
    compare();
    @(posedge rclk);
    advance();
  endtask

  task automatic settle(input string nm);
    int i;
    for (i = 0; i < 500 && (m_ph != 0 || req_hold != 0); i++) step();
    chk(nm, m_ph == 0 && req_hold == 0, 1);
  endtask

  task automatic wait_grants(input string nm, input int n);
    for (int i = 0; i < 300 && g_log.size() < n; i++) step();
    chk(nm, g_log.size() >= n, 1);
  endtask

  initial begin
    int nl;
    model_reset();
    clr_logs();
    repeat (3) step();
    hold_rst = 0;
    repeat (2) step();

    // idle: no requests with a non-empty FIFO
    clr_logs();
    req_hold = '0;
    repeat (20) step();
    chk("idle_grants", g_log.size(), 0);
    chk("idle_pops", pop_cnt, 0);

    // all requesters, single-word bursts
    clr_logs();
    clr_on_gnt = 0; len_fix = '0; req_hold = 4'b1111;
    wait_grants("rr_wait", 5);
    req_hold = '0;
    settle("rr_settle");
    clr_on_gnt = 1;
    chk("rr_g0", g_log[0], 0);
    chk("rr_g1", g_log[1], 1);
    chk("rr_g2", g_log[2], 2);
    chk("rr_g3", g_log[3], 3);
    chk("rr_g4", g_log[4], 0);
    nl = 0;
    for (int i = 0; i < o_last.size(); i++) nl += o_last[i];
    chk("rr_nout", o_data.size(), 5);
    chk("rr_nlast", nl, 5);

    // requester 2, four words 0xA0..0xA3
    clr_logs();
    nxt_word = 32'hA0; len_fix = 16'h0300; req_hold = 4'b0100;
    settle("a0_settle");
    chk("a0_nout", o_data.size(), 4);
    for (int i = 0; i < 4 && i < o_data.size(); i++) begin
      chk("a0_data", o_data[i], 32'hA0 + i);
      chk("a0_id", o_id[i], 2);
      chk("a0_last", o_last[i], i == 3);
    end
    if (pop_cyc.size() == 4 && o_cyc.size() == 4) begin
      chk("a0_b2b", pop_cyc[3] - pop_cyc[0], 3);
      chk("a0_lat", o_cyc[0] - pop_cyc[0], 2);
    end

    // length-8 burst with a 10-cycle empty stall after pop 3
    clr_logs();
    len_fix = 16'h0070; req_hold = 4'b0010;
    for (int i = 0; i < 100 && pop_cnt < 3; i++) step();
    chk("stall_reach", pop_cnt, 3);
    empty_force = 1;
    repeat (10) step();
    chk("stall_pops", pop_cnt, 3);
    empty_force = 0;
    settle("stall_settle");
    chk("stall_nout", o_data.size(), 8);
    nl = 0;
    for (int i = 0; i < o_last.size(); i++) nl += o_last[i];
    chk("stall_nlast", nl, 1);
    if (o_last.size() == 8) chk("stall_last8", o_last[7], 1);

    // async reset mid-burst of requester 0
    clr_logs();
    len_fix = 16'h0005; req_hold = 4'b0001;
    for (int i = 0; i < 100 && pop_cnt < 2; i++) step();
    chk("rst_reach", pop_cnt, 2);
    #2;
    hold_rst = 1; rst_n = 0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ol", out_last, 0);
    chk("rst_id", out_id, 0);
    req_hold = 4'b0011; len_fix = '0;
    clr_logs();
    repeat (2) step();
    hold_rst = 0;
    wait_grants("rst_wait", 1);
    chk("rst_first_gnt", g_log[0], 0);
    chk("rst_no_stale", o_data.size(), 0);
    settle("rst_settle");

    // request raised while requester 3 drains
    clr_logs();
    len_fix = 16'h2000; req_hold = 4'b1000;
    for (int i = 0; i < 100 && m_ph != 3; i++) step();
    chk("drain_reach", m_ph, 3);
    req_hold[1] = 1;
    wait_grants("drain_wait", 2);
    chk("drain_g0", g_log[0], 3);
    chk("drain_g1", g_log[1], 1);
    chk("drain_busy_before", gp_busy, 0);
    settle("drain_settle");

    // randomized traffic
    arr_rate = 6; len_rand = 1; empty_rate = 4;
    repeat (1500) step();
    arr_rate = 0;
    settle("rand_settle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_sched.md
FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 Parameter WIDTH, default 32, data word width; matches the FIFO read data width.
REQ-002 Parameter NREQ, default 4, number of requesters sharing the FIFO read port.
REQ-003 Parameter LEN_W, default 4, burst-length field width; burst words = field value + 1 (1..16).
REQ-004 Parameter RD_LAT, default 2, fixed rclk cycles from a rinc pulse to valid rdata.
REQ-005 rclk  in  1  read-domain clock; all state on rising edge.
REQ-006 rst_n  in  1  reset: rst_n, asynchronous, active-low; clock rclk.
REQ-007 req  in  NREQ  per-requester burst request level; held until granted.
REQ-008 req_len  in  NREQ*LEN_W  per-requester length field; slice i belongs to req[i].
REQ-009 gnt  out  NREQ  one-hot single-cycle grant pulse.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 rempty  in  1  FIFO empty flag, registered in rclk domain.
REQ-012 rinc  out  1  FIFO pop strobe.
REQ-013 rdata  in  WIDTH  FIFO read data, valid RD_LAT cycles after the pop.
REQ-014 out_valid  out  1  returned word valid.
REQ-015 out_data  out  WIDTH  returned word.
REQ-016 out_id  out  $clog2(NREQ)  index of the requester owning out_data.
REQ-017 out_last  out  1  final word of the burst; only with out_valid.

Function
REQ-018 FSM states IDLE, GRANT, BURST, DRAIN; reset state IDLE.
REQ-019 IDLE -> GRANT when any req bit is high; otherwise remain in IDLE.
REQ-020 GRANT lasts exactly one cycle: pulses gnt[w], latches id w and remaining = req_len[w]+1, then -> BURST.
REQ-021 Winner w is the first asserted req bit searching upward, with wrap, from (last granted index + 1) mod NREQ; the pointer resets to NREQ-1, so index 0 wins first.
REQ-022 The pointer updates to w only in GRANT.
REQ-023 In BURST: rinc = !rempty and remaining != 0; each rinc decrements remaining by 1.
REQ-024 rempty high in BURST: rinc is low and remaining holds (stall); no timeout.
REQ-025 BURST -> DRAIN in the cycle after the pop that takes remaining to 0.
REQ-026 rinc is never asserted outside BURST, and never while rempty=1.
REQ-027 A RD_LAT-deep shift register carries {valid,last} per pop; last is set on the pop with remaining=1.
REQ-028 out_valid, out_last are the shift-register outputs; out_data = rdata in that cycle; out_id = latched id.
REQ-029 The returned-word path has no backpressure; the requester accepts every out_valid.
REQ-030 DRAIN -> IDLE once the shift register holds no valid entry, so out_last precedes IDLE by at least one cycle.
REQ-031 req changes during GRANT/BURST/DRAIN are ignored until IDLE; a requester that keeps req high is eligible again after the others.
REQ-032 Outputs are registered except rinc and out_data.
REQ-033 With a continuously non-empty FIFO, a burst of N words takes N consecutive rinc cycles.

Reset
REQ-034 rst_n low asynchronously clears: state=IDLE, gnt=0, busy=0, rinc=0, out_valid=0, out_last=0, out_id=0, remaining=0, pipe=0, pointer=NREQ-1.
REQ-035 Reset mid-burst discards in-flight words; no out_valid appears after rst_n rises until a new grant and pop.

Structure
REQ-036 A shared package holds the FSM state enum, RD_LAT default, and the grant-index width function.
REQ-037 The round-robin arbiter is one sub-module, rr_arb, combinational winner plus registered pointer, reused by the other schedulers.

Verification
REQ-038 All req=4'b0000, FIFO non-empty for 20 cycles -> rinc, gnt and busy stay 0.
REQ-039 req=4'b1111 held, all lengths 0 -> grants to 0,1,2,3,0 in order, one word each, out_last on every word.
REQ-040 req[2] with length 3, FIFO holding words 0xA0..0xA3 -> four back-to-back rinc; out_data 0xA0..0xA3 at pop+2 with out_id=2; out_last on 0xA3.
REQ-041 Length 7 burst, rempty forced high after pop 3 for 10 cycles -> rinc held low while empty; pops 4..8 resume; exactly 8 out_valid, out_last on the 8th.
REQ-042 rst_n pulsed low after pop 2 of a 6-word burst -> all outputs 0 immediately; no out_valid afterwards; next grant goes to requester 0.
REQ-043 req[1] raised in DRAIN of requester 3's burst -> gnt[1] only after busy falls, in the GRANT cycle after IDLE.
